// File: rtl/cpack_pkg.sv
// cpack_pkg: shared widths, code prefixes, code lengths and FSM states for the word compressor.
package cpack_pkg;
  localparam int WIDTH_DATA_IN = 128;
  localparam int WIDTH = 32;
  localparam int WORD = 16;
  localparam int IDX_W = $clog2(WORD);
  localparam int ACC_WIDTH = 196;
  localparam int CODE_W = 34;
  typedef enum logic [1:0] {C_ZZZZ = 2'b00, C_XXXX = 2'b01, C_MMMM = 2'b10, C_BAK = 2'b11} code_e;
  typedef enum logic [1:0] {B_MMXX = 2'b00, B_ZZZX = 2'b01, B_MMMX = 2'b10} code_bak_e;
  localparam logic [5:0] LEN_ZZZZ = 6'd2;
  localparam logic [5:0] LEN_XXXX = 6'd34;
  localparam logic [5:0] LEN_MMMM = 6'd6;
  localparam logic [5:0] LEN_MMXX = 6'd24;
  localparam logic [5:0] LEN_ZZZX = 6'd12;
  localparam logic [5:0] LEN_MMMX = 6'd16;
  typedef enum logic [1:0] {IDLE, P0, P1, FLUSH} state_e;
endpackage

// File: rtl/word_encoder.sv
// word_encoder: classifies one word against the dictionary and builds its variable-length code.
module word_encoder
  import cpack_pkg::*;
(
  input  logic [WIDTH-1:0]           word_i,
  input  logic [WORD-1:0][WIDTH-1:0] dict_i,
  input  logic [WORD-1:0]            valid_i,
  output logic [5:0]                 len_o,
  output logic [CODE_W-1:0]          bits_o,
  output logic                       push_o
);
  logic [IDX_W-1:0] idx_m, idx_8, idx_16;
  logic hit_m, hit_8, hit_16;
  code_e pre;
  code_bak_e bak;
  // Descending scan so the lowest matching index wins.
  always_comb begin
    {hit_m, hit_8, hit_16} = '0;
    {idx_m, idx_8, idx_16} = '0;
    for (int i = WORD-1; i >= 0; i--) begin
      if (valid_i[i]) begin
        if (dict_i[i] == word_i) begin hit_m = 1'b1; idx_m = IDX_W'(i); end
        if (dict_i[i][WIDTH-1:8] == word_i[WIDTH-1:8]) begin hit_8 = 1'b1; idx_8 = IDX_W'(i); end
        if (dict_i[i][WIDTH-1:16] == word_i[WIDTH-1:16]) begin hit_16 = 1'b1; idx_16 = IDX_W'(i); end
      end
    end
  end
  always_comb begin
    pre = word_i == '0 ? C_ZZZZ : hit_m ? C_MMMM
        : (word_i[WIDTH-1:8] == '0 || hit_8 || hit_16) ? C_BAK : C_XXXX;
    bak = word_i[WIDTH-1:8] == '0 ? B_ZZZX : hit_8 ? B_MMMX : B_MMXX;
  end
  assign bits_o = pre == C_ZZZZ ? CODE_W'(pre)
                : pre == C_XXXX ? {word_i, pre}
                : pre == C_MMMM ? CODE_W'({idx_m, pre})
                : bak == B_ZZZX ? CODE_W'({word_i[7:0], bak, pre})
                : bak == B_MMMX ? CODE_W'({word_i[7:0], idx_8, bak, pre})
                : CODE_W'({word_i[15:0], idx_16, bak, pre});
  assign len_o = pre == C_ZZZZ ? LEN_ZZZZ : pre == C_XXXX ? LEN_XXXX : pre == C_MMMM ? LEN_MMMM
               : bak == B_ZZZX ? LEN_ZZZX : bak == B_MMMX ? LEN_MMMX : LEN_MMXX;
  assign push_o = pre == C_XXXX || (pre == C_BAK && bak != B_ZZZX);
endmodule

// File: rtl/compressor.sv
// compressor: encodes 128-bit lines two words per cycle and packs the codes LSB-first
// into 128-bit output lines with valid/ready handshakes on both sides.
module compressor
  import cpack_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [WIDTH_DATA_IN-1:0] i_data,
  input  logic                     i_last,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [WIDTH_DATA_IN-1:0] o_data,
  output logic                     o_last
);
  state_e state_q;
  logic [WIDTH_DATA_IN-1:0] line_q;
  logic last_q;
  logic [WORD-1:0][WIDTH-1:0] dict_q, dict_fwd;
  logic [WORD-1:0] valid_q, valid_fwd;
  logic [IDX_W-1:0] ptr_q;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [7:0] fill_q, fill_d;
  logic [WIDTH-1:0] w0, w1;
  logic [5:0] len0, len1;
  logic [CODE_W-1:0] bits0, bits1;
  logic [2*CODE_W-1:0] pair;
  logic push0, push1, stall, emit;
  assign stall = o_valid & ~i_ready;
  assign o_ready = ~stall & (state_q == IDLE || (state_q == P1 && !last_q));
  assign {w1, w0} = state_q == P1 ? line_q[WIDTH_DATA_IN-1:2*WIDTH] : line_q[2*WIDTH-1:0];
  // The second word must see the first word's dictionary push of the same cycle.
  always_comb begin
    dict_fwd = dict_q;
    valid_fwd = valid_q;
    if (push0) begin
      dict_fwd[ptr_q] = w0;
      valid_fwd[ptr_q] = 1'b1;
    end
  end
  word_encoder u_enc0 (.word_i(w0), .dict_i(dict_q), .valid_i(valid_q),
                       .len_o(len0), .bits_o(bits0), .push_o(push0));
  word_encoder u_enc1 (.word_i(w1), .dict_i(dict_fwd), .valid_i(valid_fwd),
                       .len_o(len1), .bits_o(bits1), .push_o(push1));
  assign pair = (2*CODE_W)'(bits0) | ((2*CODE_W)'(bits1) << len0);
  assign acc_d = acc_q | (ACC_WIDTH'(pair) << fill_q);
  assign fill_d = fill_q + 8'(len0) + 8'(len1);
  assign emit = fill_d >= 8'd128;
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      line_q <= '0;
      last_q <= 1'b0;
      dict_q <= '0;
      valid_q <= '0;
      ptr_q <= '0;
      acc_q <= '0;
      fill_q <= '0;
      o_valid <= 1'b0;
      o_last <= 1'b0;
      o_data <= '0;
    end else if (!stall) begin
      if (o_valid) begin
        o_valid <= 1'b0;
        o_last <= 1'b0;
      end
      case (state_q)
        IDLE: if (i_valid) begin
          line_q <= i_data;
          last_q <= i_last;
          state_q <= P0;
        end
        P0, P1: begin
          if (push0) begin
            dict_q[ptr_q] <= w0;
            valid_q[ptr_q] <= 1'b1;
          end
          if (push1) begin
            dict_q[ptr_q + IDX_W'(push0)] <= w1;
            valid_q[ptr_q + IDX_W'(push0)] <= 1'b1;
          end
          ptr_q <= ptr_q + IDX_W'(push0) + IDX_W'(push1);
          if (emit) begin
            o_data <= acc_d[WIDTH_DATA_IN-1:0];
            o_valid <= 1'b1;
            o_last <= state_q == P1 && last_q && fill_d == 8'd128;
            acc_q <= acc_d >> WIDTH_DATA_IN;
            fill_q <= fill_d - 8'd128;
          end else begin
            acc_q <= acc_d;
            fill_q <= fill_d;
          end
          if (state_q == P0) state_q <= P1;
          else if (last_q) state_q <= FLUSH;
          else if (i_valid) begin
            line_q <= i_data;
            last_q <= i_last;
            state_q <= P0;
          end else state_q <= IDLE;
        end
        FLUSH: begin
          // Bits above fill are always zero, so acc is already the padded line.
          if (fill_q != 8'd0 || !(o_valid && o_last)) begin
            o_data <= acc_q[WIDTH_DATA_IN-1:0];
            o_valid <= 1'b1;
            o_last <= 1'b1;
          end
          acc_q <= '0;
          fill_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_compressor.sv
// tb_compressor: random and directed lines scored against a bit-queue reference encoder.
module tb_compressor;
  logic clk = 1'b0, rst_n = 1'b1, i_valid = 1'b0, i_last = 1'b0, i_ready = 1'b1;
  logic [127:0] i_data = '0;
  logic o_ready, o_valid, o_last;
  logic [127:0] o_data;
  typedef struct packed {logic [127:0] d; logic l;} exp_t;
  exp_t sb[$];
  exp_t m_e;
  logic [127:0] rx_q[$];
  int n_vec = 0, n_err = 0;
  bit rdy_force = 1'b1, rdy_val = 1'b1;
  logic [31:0] m_dict[16];
  bit m_val[16];
  int m_ptr = 0;
  bit bq[$];
  logic [31:0] hist[16];
  int hp = 0;
  logic [31:0] wl[20];

  compressor dut (.i_clk(clk), .i_reset(rst_n), .i_valid(i_valid), .o_ready(o_ready),
                  .i_data(i_data), .i_last(i_last), .o_valid(o_valid), .i_ready(i_ready),
                  .o_data(o_data), .o_last(o_last));

  always #5 clk = ~clk;

  function automatic void put(logic [63:0] v, int n);
    for (int i = 0; i < n; i++) bq.push_back(v[i]);
  endfunction

  function automatic void model_word(logic [31:0] w);
    int hm = -1, h8 = -1, h16 = -1;
    for (int i = 15; i >= 0; i--) if (m_val[i]) begin
      if (m_dict[i] == w) hm = i;
      if (m_dict[i][31:8] == w[31:8]) h8 = i;
      if (m_dict[i][31:16] == w[31:16]) h16 = i;
    end
    if (w == 0) put(64'd0, 2);
    else if (hm >= 0) put({hm[3:0], 2'b10}, 6);
    else if (w[31:8] == 0) put({w[7:0], 4'b0111}, 12);
    else begin
      if (h8 >= 0) put({w[7:0], h8[3:0], 4'b1011}, 16);
      else if (h16 >= 0) put({w[15:0], h16[3:0], 4'b0011}, 24);
      else put({w, 2'b01}, 34);
      m_dict[m_ptr] = w;
      m_val[m_ptr] = 1'b1;
      m_ptr = (m_ptr + 1) % 16;
    end
  endfunction

  function automatic void model_line(logic [127:0] d, bit l);
    logic [127:0] ln;
    for (int k = 0; k < 4; k++) model_word(d[32*k +: 32]);
    while (bq.size() >= 128) begin
      for (int i = 0; i < 128; i++) ln[i] = bq.pop_front();
      sb.push_back({ln, 1'b0});
    end
    if (l) begin
      if (bq.size() > 0) begin
        ln = '0;
        for (int i = 0; bq.size() > 0; i++) ln[i] = bq.pop_front();
        sb.push_back({ln, 1'b1});
      end else if (sb.size() > 0) sb[sb.size()-1].l = 1'b1;
      else sb.push_back({128'h0, 1'b1});
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) m_val[i] = 1'b0;
    m_ptr = 0;
    bq.delete();
    sb.delete();
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] h = hist[$urandom_range(0, 15)];
    logic [31:0] w;
    case ($urandom_range(0, 5))
      0: w = 32'h0;
      1: w = 32'($urandom_range(1, 255));
      2: w = h;
      3: w = {h[31:8], 8'($urandom)};
      4: w = {h[31:16], 16'($urandom)};
      default: w = $urandom;
    endcase
    hist[hp] = w;
    hp = (hp + 1) % 16;
    return w;
  endfunction

  function automatic logic [33:0] sbits(int pos, int n);
    logic [33:0] r = '0;
    for (int i = 0; i < n; i++) r[i] = rx_q[(pos+i)/128][(pos+i)%128];
    return r;
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [127:0] got, input logic [127:0] want);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic check_reset(input string nm);
    chk(o_valid === 1'b0, {nm, "_o_valid"}, 128'(o_valid), 128'd0);
    chk(o_last === 1'b0, {nm, "_o_last"}, 128'(o_last), 128'd0);
    chk(o_data === '0, {nm, "_o_data"}, o_data, 128'd0);
    chk(o_ready === 1'b1, {nm, "_o_ready"}, 128'(o_ready), 128'd1);
  endtask

  task automatic send_line(input logic [127:0] d, input bit l);
    int t = 0;
    i_valid = 1'b1;
    i_data = d;
    i_last = l;
    @(negedge clk);
    while (!o_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!o_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL accept: o_ready stuck at %0b, want 1", o_ready);
    end else model_line(d, l);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d lines outstanding, want 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    i_valid = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    i_ready = rdy_force ? rdy_val : ($urandom_range(0, 9) < 7);
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && o_valid && i_ready) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL line: got %h last=%0b, want no output", o_data, o_last);
      end else begin
        m_e = sb.pop_front();
        if (o_data !== m_e.d || o_last !== m_e.l) begin
          n_err++;
          $display("FAIL line: got %h last=%0b, want %h last=%0b", o_data, o_last, m_e.d, m_e.l);
        end
      end
      rx_q.push_back(o_data);
    end
  end

  initial begin
    logic [127:0] d, e2, cap;
    int t;
    for (int i = 0; i < 16; i++) hist[i] = $urandom;
    model_clear();
    #2 rst_n = 1'b0;
    #1 check_reset("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Zero line: four 2-bit codes, flushed as an all-zero last line.
    rx_q.delete();
    send_line(128'h0, 1'b1);
    drain();
    chk(rx_q.size() == 1, "zero_count", 128'(rx_q.size()), 128'd1);
    // Exact bit layout for xxxx, mmmm, zzzz, zzzx.
    rx_q.delete();
    send_line({32'h000000AB, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF}, 1'b1);
    drain();
    e2 = '0;
    e2[33:0] = 34'h37AB6FBBD;
    e2[39:34] = 6'b000010;
    e2[53:42] = 12'hAB7;
    chk(rx_q.size() == 1, "deadbeef_count", 128'(rx_q.size()), 128'd1);
    if (rx_q.size() == 1) chk(rx_q[0] === e2, "deadbeef_line", rx_q[0], e2);
    // Seventeen distinct words wrap the dictionary pointer.
    do_reset();
    rx_q.delete();
    for (int k = 1; k <= 17; k++) wl[k-1] = {8'(k + 16), 8'h5A, 16'hC3C3 ^ 16'(k)};
    wl[17] = wl[0];
    wl[18] = wl[16];
    wl[19] = 32'h0;
    for (int n = 0; n < 5; n++) send_line({wl[4*n+3], wl[4*n+2], wl[4*n+1], wl[4*n]}, n == 4);
    drain();
    chk(rx_q.size() == 5, "wrap_count", 128'(rx_q.size()), 128'd5);
    if (rx_q.size() == 5) begin
      chk(sbits(0, 34) === {wl[0], 2'b01}, "wrap_first", 128'(sbits(0, 34)), 128'({wl[0], 2'b01}));
      chk(sbits(578, 34) === {wl[0], 2'b01}, "wrap_w1_xxxx", 128'(sbits(578, 34)), 128'({wl[0], 2'b01}));
      chk(sbits(612, 6) === 34'b000010, "wrap_w17_mmmm", 128'(sbits(612, 6)), 128'd2);
    end
    // Back-pressure: output frozen, no input accepted, dictionary untouched.
    do_reset();
    rdy_val = 1'b0;
    i_ready = 1'b0;
    for (int k = 0; k < 4; k++) d[32*k +: 32] = {8'($urandom_range(1, 255)), 24'($urandom)};
    send_line(d, 1'b0);
    t = 0;
    while (!o_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk(o_valid === 1'b1, "stall_valid", 128'(o_valid), 128'd1);
    cap = o_data;
    repeat (5) begin
      @(negedge clk);
      chk(o_data === cap && o_ready === 1'b0 && o_valid === 1'b1, "stall_hold",
          {o_data[123:0], o_valid, o_ready}, {cap[123:0], 2'b10});
    end
    @(posedge clk);
    #1;
    rdy_val = 1'b1;
    i_ready = 1'b1;
    send_line(d, 1'b1);
    drain();
    // Four lines of fresh words under random back-pressure.
    rdy_force = 1'b0;
    for (int n = 0; n < 4; n++) send_line({$urandom, $urandom, $urandom, $urandom}, n == 3);
    drain();
    // Mixed random traffic.
    for (int n = 0; n < 150; n++) begin
      for (int k = 0; k < 4; k++) d[32*k +: 32] = rand_word();
      send_line(d, $urandom_range(0, 4) == 0 || n == 149);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    // Reset in the middle of a line.
    rdy_force = 1'b1;
    send_line({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset("midreset");
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy_force = 1'b0;
    for (int k = 0; k < 4; k++) d[32*k +: 32] = rand_word();
    send_line(d, 1'b1);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
